// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state encoding,
// mult/div wait-counter width and the NOP encoding used when a stage is cleared.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pipe_state_t;

  localparam int MD_CNT_W = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear wins over enable.
// Result is visible the cycle after the enabling cycle; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stalls for load-use and mult/div EX occupancy, flushes on taken branches; control
// outputs are combinational from state and inputs, stall cycles counted saturating.
module hazard_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic [4:0]       IDEX_Rt,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_MDStart,
  input  logic             BranchTaken,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             IFID_Flush,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [MD_CNT_W-1:0] MD_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  pipe_state_t         state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_mask_q, md_mask_d;
  logic                load_use;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    IFID_Flush   = 1'b0;
    MD_Busy      = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_mask_d    = 1'b0;

    if (reset) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      IDEX_Bubble  = 1'b1;
      EXMEM_Bubble = 1'b1;
      IFID_Flush   = 1'b1;
      state_d      = RUN;
      md_cnt_d     = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (IDEX_MDStart && !md_mask_q) begin
            // Freeze the front end and feed bubbles downstream while EX is occupied
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            MD_Busy      = 1'b1;
            md_cnt_d     = MD_LOAD;
            state_d      = MD_WAIT;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_Write   = 1'b0;
          EXMEM_Bubble = 1'b1;
          MD_Busy      = 1'b1;
          md_cnt_d     = md_cnt_q - MD_ONE;
          // Mask one cycle so the held mult/div leaves ID/EX without restarting
          if (md_cnt_q == MD_ONE) begin
            state_d   = RUN;
            md_mask_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    md_cnt_q  <= md_cnt_d;
    md_mask_q <= md_mask_d;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (!PC_Write && !reset),
    .cnt (StallCount)
  );

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; companion to the forwarding logic.
- Detects hazards that forwarding cannot resolve: load-use and multi-cycle mult/div occupancy of EX. Also applies branch-taken flushes.
- Drives the PC and pipeline-register write enables, bubbles and flushes.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MD_LATENCY, 4: total EX occupancy, in cycles, of a mult/div instruction (legal range 2..15).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- IFID_Rs  in  5  rs field of the instruction in IF/ID
- IFID_Rt  in  5  rt field of the instruction in IF/ID
- IFID_UsesRt  in  1  instruction in IF/ID reads rt
- IDEX_Rt  in  5  rt (load destination) of the instruction in ID/EX
- IDEX_MemRead  in  1  instruction in ID/EX is a load
- IDEX_MDStart  in  1  instruction in ID/EX is mult/div
- BranchTaken  in  1  branch resolved taken in EX this cycle
- PC_Write  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IDEX_Write  out  1  ID/EX load enable
- IDEX_Bubble  out  1  zero control bits entering ID/EX
- EXMEM_Bubble  out  1  zero control bits entering EX/MEM
- IFID_Flush  out  1  clear IF/ID to NOP
- MD_Busy  out  1  mult/div occupying EX
- StallCount  out  CNT_W  saturating count of cycles with PC_Write=0

Behaviour:
- One clock: clk. Reset is synchronous and active-high on the port named reset.
- Registered state: FSM {RUN, MD_WAIT}, down-counter md_cnt (4 bits), one-cycle flag md_mask, StallCount.
- Control outputs are combinational from state and inputs.
- Defaults: PC_Write, IFID_Write and IDEX_Write are 1; IDEX_Bubble, EXMEM_Bubble, IFID_Flush and MD_Busy are 0.
- Reset: whenever reset=1, the next state is RUN, md_cnt=0, md_mask=0 and StallCount=0.
  - During the reset cycle, outputs are forced to: PC_Write, IFID_Write and IDEX_Write = 0; IDEX_Bubble, EXMEM_Bubble and IFID_Flush = 1; MD_Busy = 0.
  - Reset while in MD_WAIT aborts the wait immediately.
- load_use = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- In RUN, the first matching rule applies (priority order):
  1. BranchTaken: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1 (PC takes the target). Stay in RUN. Load-use and MDStart are ignored this cycle.
  2. IDEX_MDStart && !md_mask: PC_Write, IFID_Write and IDEX_Write = 0; EXMEM_Bubble=1; MD_Busy=1. Load md_cnt=MD_LATENCY-1 and go to MD_WAIT. A concurrent load_use is not applied; it is re-evaluated after the wait.
  3. load_use: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly this cycle. IDEX_Write stays 1 so the bubble enters. Stay in RUN.
  4. Otherwise, defaults.
- md_mask is set for exactly the cycle after leaving MD_WAIT. This lets the held mult/div advance out of ID/EX without retriggering.
- MD_WAIT:
  - Outputs are the same as rule 2. BranchTaken and load_use are ignored.
  - md_cnt decrements each cycle.
  - When md_cnt==1: go to RUN and set md_mask.
  - Total freeze is exactly MD_LATENCY cycles, counting the start cycle.
- StallCount increments each cycle that PC_Write=0 and reset=0. It holds at 2^CNT_W-1 (no wrap).
- Back-to-back mult/div: the second MD starts in the cycle after md_mask clears.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state enum (RUN, MD_WAIT) and localparams for the md_cnt width and the NOP encoding.
- One sub-module: sat_counter (width-parameterised, enable, synchronous clear, saturating). Instantiated for StallCount.

Test Plan:
- Load r8 in ID/EX, IFID_Rs=8 -> exactly 1 cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1; StallCount 0->1.
- Load with IDEX_Rt=0 matching IFID_Rs=0 -> no stall. IFID_Rt match with IFID_UsesRt=0 -> no stall.
- IDEX_MDStart held, MD_LATENCY=4 -> MD_Busy high 4 cycles, then 1 cycle with md_mask and no restall; StallCount=4.
- BranchTaken together with load_use and MDStart -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, no stall, state stays RUN.
- reset asserted on the 2nd MD_WAIT cycle -> next cycle state RUN, MD_Busy=0, StallCount=0; forced reset outputs seen during the reset cycle.
- Force 65540 stall cycles (CNT_W=16) -> StallCount saturates at 0xFFFF.
